// File: rtl/muldiv_ctrl.sv
// Sequencing controller between EX and the shared multiply/divide unit.
// Divide-by-zero and signed-overflow results are produced locally without the divider.
module muldiv_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid_i,
  input  logic [2:0]      funct3_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            flush_i,
  output logic            mul_en_o,
  output logic            req_valid_o,
  output logic [XLEN-1:0] op_1_o,
  output logic [XLEN-1:0] op_2_o,
  output logic            sign_op_1_o,
  output logic            sign_op_2_o,
  input  logic            unit_ready_i,
  input  logic            unit_valid_i,
  input  logic [XLEN-1:0] data_1_i,
  input  logic [XLEN-1:0] data_2_i,
  output logic            stall_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o,
  output logic            busy_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]      r_state;
  logic [2:0]      r_funct3;
  logic            r_word;
  logic            r_mul_en;
  logic            r_sign1;
  logic            r_sign2;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [XLEN-1:0] r_result;

  logic            w_sign1;
  logic            w_sign2;
  logic            w_div_zero;
  logic            w_overflow;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic [XLEN-1:0] w_local_raw;
  logic [XLEN-1:0] w_unit_raw;

  // W-form results take bit 31 of the selected value as the sign.
  function automatic logic [XLEN-1:0] fmt_result(input logic word, input logic [XLEN-1:0] value);
    fmt_result = word ? {{(XLEN-32){value[31]}}, value[31:0]} : value;
  endfunction

  always_comb begin
    w_sign1 = (funct3_i == 3'd0) || (funct3_i == 3'd1) || (funct3_i == 3'd2) ||
              (funct3_i == 3'd4) || (funct3_i == 3'd6);
    w_sign2 = (funct3_i == 3'd0) || (funct3_i == 3'd1) ||
              (funct3_i == 3'd4) || (funct3_i == 3'd6);
    if (word_i) begin
      w_op1 = {{(XLEN-32){w_sign1 & src1_i[31]}}, src1_i[31:0]};
      w_op2 = {{(XLEN-32){w_sign2 & src2_i[31]}}, src2_i[31:0]};
    end else begin
      w_op1 = src1_i;
      w_op2 = src2_i;
    end
    w_div_zero = funct3_i[2] &
                 (word_i ? (src2_i[31:0] == 32'd0) : (src2_i == '0));
    w_overflow = funct3_i[2] & ~funct3_i[0] &
                 (word_i ? ((src1_i[31:0] == 32'h8000_0000) && (src2_i[31:0] == 32'hFFFF_FFFF))
                         : ((src1_i == {1'b1, {(XLEN-1){1'b0}}}) && (src2_i == '1)));
    // funct3[1] distinguishes remainder from quotient among the divide ops
    if (w_div_zero) begin
      w_local_raw = funct3_i[1] ? w_op1 : '1;
    end else begin
      w_local_raw = funct3_i[1] ? '0 : w_op1;
    end
    w_unit_raw = ((r_funct3 == 3'd0) || (r_funct3[2] && !r_funct3[1])) ? data_1_i : data_2_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_funct3 <= 3'd0;
      r_word   <= 1'b0;
      r_mul_en <= 1'b0;
      r_sign1  <= 1'b0;
      r_sign2  <= 1'b0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (op_valid_i && !flush_i) begin
            r_funct3 <= funct3_i;
            r_word   <= word_i;
            r_mul_en <= ~funct3_i[2];
            r_sign1  <= w_sign1;
            r_sign2  <= w_sign2;
            r_op1    <= w_op1;
            r_op2    <= w_op2;
            if (w_div_zero || w_overflow) begin
              r_result <= fmt_result(word_i, w_local_raw);
              r_state  <= S_DONE;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        // A flush that coincides with an accept leaves a result in flight to drain.
        S_ISSUE: begin
          if (flush_i) begin
            r_state <= unit_ready_i ? S_DRAIN : S_IDLE;
          end else if (unit_ready_i) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush_i) begin
            r_state <= unit_valid_i ? S_IDLE : S_DRAIN;
          end else if (unit_valid_i) begin
            r_result <= fmt_result(r_word, w_unit_raw);
            r_state  <= S_DONE;
          end
        end
        S_DRAIN: begin
          if (unit_valid_i) begin
            r_state <= S_IDLE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mul_en_o       = r_mul_en;
  assign op_1_o         = r_op1;
  assign op_2_o         = r_op2;
  assign sign_op_1_o    = r_sign1;
  assign sign_op_2_o    = r_sign2;
  assign req_valid_o    = (r_state == S_ISSUE);
  assign result_o       = r_result;
  assign result_valid_o = (r_state == S_DONE) && !flush_i;
  assign stall_o        = op_valid_i & ~result_valid_o;
  assign busy_o         = (r_state != S_IDLE);

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencing controller between the EX stage and the shared multiply/divide unit (one multiplier plus one divider behind a single `mul_en` select).
- Decodes RV64M ops and prepares signed, unsigned and word-form operands.
- Issues each request over the unit's req_valid/ready/valid handshake and stalls EX until the result is back.
- Resolves divide-by-zero and signed overflow locally without using the divider, handles pipeline flush, and returns one formatted XLEN result.

Parameters:
- XLEN, 64, datapath width; equals `RegBus` width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- op_valid_i  in  1  EX holds an M-extension op; held stable while stall_o=1
- funct3_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- word_i  in  1  W-form op (MULW/DIVW/DIVUW/REMW/REMUW)
- src1_i  in  XLEN  rs1 value
- src2_i  in  XLEN  rs2 value
- flush_i  in  1  kill the in-flight EX op
- mul_en_o  out  1  1 selects the multiplier, 0 the divider
- req_valid_o  out  1  request to the unit
- op_1_o  out  XLEN  prepared operand 1
- op_2_o  out  XLEN  prepared operand 2
- sign_op_1_o  out  1  operand 1 signed
- sign_op_2_o  out  1  operand 2 signed
- unit_ready_i  in  1  unit accepts request
- unit_valid_i  in  1  unit result valid, 1-cycle pulse
- data_1_i  in  XLEN  product low / quotient
- data_2_i  in  XLEN  product high / remainder
- stall_o  out  1  stall EX
- result_o  out  XLEN  final rd value
- result_valid_o  out  1  result_o valid, 1-cycle pulse
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; all registered outputs 0; result_o=0; any in-flight unit result is ignored.
- stall_o = op_valid_i & ~result_valid_o (combinational).
- Operand preparation, latched in IDLE on accept:
  - sign_op_1 = 1 for MUL, MULH, MULHSU, DIV, REM.
  - sign_op_2 = 1 for MUL, MULH, DIV, REM.
  - W-form: operands = low 32 bits, sign-extended if the op is signed, else zero-extended. MULW is always signed.
  - mul_en = ~funct3[2].
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE:
  - On op_valid_i & ~flush_i, latch operands and control.
  - If a divide op with zero divisor or signed overflow → DONE with the local result.
  - Otherwise → ISSUE.
  - Zero divisor and overflow are tested on 32-bit values for W-form, 64-bit otherwise.
- ISSUE:
  - req_valid_o=1; ops and sign bits stable.
  - On unit_ready_i → WAIT; accept is req_valid_o & unit_ready_i in the same cycle.
  - If flush_i: → DRAIN when unit_ready_i is also 1, else → IDLE. Withdrawing req_valid on flush is permitted.
- WAIT:
  - req_valid_o=0.
  - On unit_valid_i → DONE; result_o is registered that cycle.
  - If flush_i → DRAIN; if unit_valid_i arrives in the same cycle → IDLE, result discarded.
- DRAIN: stall_o follows the formula; on unit_valid_i → IDLE, result discarded. A new op is not issued until IDLE.
- DONE:
  - result_valid_o=1 for exactly one cycle → IDLE.
  - If flush_i is high in DONE, result_valid_o is forced 0.
- Result selection:
  - MUL → data_1; MULH/MULHSU/MULHU → data_2.
  - DIV/DIVU → data_1; REM/REMU → data_2.
  - W-form: sign-extend bit 31 of the selected value.
- Local results:
  - Divisor zero: quotient = all ones (W-form: sign-extended 0xFFFFFFFF); remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend, remainder = 0.
  - Latency: accept → result_valid_o in 1 cycle.
- Minimum latency with unit: accept, then ISSUE, WAIT, DONE; result_valid_o comes one cycle after unit_valid_i.
- unit_valid_i outside WAIT/DRAIN is ignored.
- op_valid_i deasserting without flush_i while busy is a protocol error and is not handled.

Test Plan:
- MULHU src1=0xFFFF_FFFF_FFFF_FFFF, src2=2, unit returns data_2=1 → sign_op_1_o=0, sign_op_2_o=0, result_o=0x1, one result_valid_o pulse, stall_o low the same cycle.
- DIVW src1=0x0000_0000_8000_0000, src2=0xFFFF_FFFF_FFFF_FFFF → no req_valid_o, result_o=0xFFFF_FFFF_8000_0000 one cycle after accept.
- REMU src2=0, src1=0x1234 → no req_valid_o, result_o=0x1234; DIVU with the same operands → result_o=0xFFFF_FFFF_FFFF_FFFF.
- MULW src1=0x7FFF_FFFF, src2=2, unit_ready_i delayed 3 cycles → req_valid_o held 4 cycles with op_1_o=0x7FFF_FFFF and op_2_o stable; data_1=0xFFFF_FFFE → result_o=0xFFFF_FFFF_FFFF_FFFE.
- DIV accepted, flush_i in WAIT, unit_valid_i 5 cycles later, next MUL presented meanwhile → no result_valid_o for the DIV, busy_o high until the discarded valid, then the MUL issues and completes correctly.
- rst=0 asserted in WAIT → next cycle all outputs 0, state IDLE; a late unit_valid_i produces no result_valid_o.
